sti_dac_sequencer: RTL and testbench

Controller for the serial transmit / data-arrange path. It accepts one 16-bit parallel frame per load, serializes it into a 8/16/24/32-bit stream, and packs every 8 streamed bits into a byte. Each byte is written to an 8-bit-wide DAC memory at an auto-incremented address. On the last frame it zero-fills the remaining memory and pulses done.

---
 rtl/sti_dac_sequencer_pkg.sv | 39 +++
 rtl/sti_dac_sequencer_byte_packer.sv | 33 +++
 rtl/sti_dac_sequencer.sv | 111 +++++++++++
 tb/tb_sti_dac_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sti_dac_sequencer_pkg.sv
// Shared types and helpers for the serial-transmit / DAC-arrange sequencer.
package sti_dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LAST_WR,
    ST_FILL,
    ST_DONE
  } state_t;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  // Stream length in bits: 8, 16, 24 or 32.
  function automatic logic [5:0] bit_count(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction

  // Right-aligned frame word; only the low bit_count(len) bits are streamed.
  function automatic logic [31:0] frame_word(input logic [15:0] data,
                                             input logic [1:0]  len,
                                             input logic        fill,
                                             input logic        low);
    logic [31:0] w;
    w = 32'h0;
    case (len)
      LEN_8:   w = {24'h0, (low ? data[7:0] : data[15:8])};
      LEN_16:  w = {16'h0, data};
      LEN_24:  w = fill ? {8'h0, data, 8'h00} : {16'h0, data};
      LEN_32:  w = fill ? {data, 16'h0000} : {16'h0, data};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sti_dac_sequencer_byte_packer.sv
// Packs the serial stream into bytes, first bit of a group landing in bit 7.
module sti_dac_sequencer_byte_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic       byte_we,
  output logic [7:0] byte_data
);

  logic [7:0] sr_q;
  logic [2:0] cnt_q;
  logic       we_q;

  // The write strobe lands the cycle after the 8th bit, when sr_q holds the full byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= 8'h00;
      cnt_q <= 3'd0;
      we_q  <= 1'b0;
    end else begin
      we_q <= bit_valid && (cnt_q == 3'd7);
      if (bit_valid) begin
        sr_q  <= {sr_q[6:0], bit_data};
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  assign byte_we   = we_q;
  assign byte_data = sr_q;

endmodule

// File: rtl/sti_dac_sequencer.sv
// Frame sequencer: serializes a captured frame, writes packed bytes to DAC
// memory at an auto-incremented address, and zero-fills memory after the last frame.
module sti_dac_sequencer
  import sti_dac_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [15:0]       pi_data,
  input  logic [1:0]        pi_length,
  input  logic              pi_fill,
  input  logic              pi_msb,
  input  logic              pi_low,
  input  logic              pi_end,
  output logic              busy,
  output logic              so_valid,
  output logic              so_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              done
);

  state_t            state, state_nx;
  logic [31:0]       word_q;
  logic [4:0]        last_q;
  logic [4:0]        k_q;
  logic              msb_q;
  logic              end_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_hold_q;
  logic              pk_we;
  logic [7:0]        pk_byte;
  logic              accept;
  logic              fill_we;
  logic              top_addr;
  logic [4:0]        bit_idx;

  assign accept   = (state == ST_IDLE) && load;
  assign top_addr = &addr_q;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (load) state_nx = ST_SHIFT;
      ST_SHIFT:   if (k_q == last_q) state_nx = ST_LAST_WR;
      ST_LAST_WR: begin
        // Writing the top address now means memory is exactly full: skip the fill.
        if (!end_q)        state_nx = ST_IDLE;
        else if (top_addr) state_nx = ST_DONE;
        else               state_nx = ST_FILL;
      end
      ST_FILL:    if (top_addr) state_nx = ST_DONE;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    so_valid = (state == ST_SHIFT);
    bit_idx  = msb_q ? (last_q - k_q) : k_q;
    so_data  = so_valid & word_q[bit_idx];
    fill_we  = (state == ST_FILL);
    mem_we   = pk_we | fill_we;
    mem_addr = addr_q;
    mem_data = data_hold_q;
    if (pk_we)        mem_data = pk_byte;
    else if (fill_we) mem_data = 8'h00;
    done     = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      word_q      <= 32'h0;
      last_q      <= 5'd0;
      k_q         <= 5'd0;
      msb_q       <= 1'b0;
      end_q       <= 1'b0;
      addr_q      <= '0;
      data_hold_q <= 8'h00;
    end else begin
      state       <= state_nx;
      data_hold_q <= mem_data;
      if (accept) begin
        word_q <= frame_word(pi_data, pi_length, pi_fill, pi_low);
        last_q <= 5'(bit_count(pi_length) - 6'd1);
        msb_q  <= pi_msb;
        end_q  <= pi_end;
        k_q    <= 5'd0;
      end else if (so_valid) begin
        k_q <= k_q + 5'd1;
      end
      if (state == ST_DONE) addr_q <= '0;
      else if (mem_we)      addr_q <= addr_q + 1'b1;
    end
  end

  sti_dac_sequencer_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (so_valid),
    .bit_data  (so_data),
    .byte_we   (pk_we),
    .byte_data (pk_byte)
  );

endmodule

// File: tb/tb_sti_dac_sequencer.sv
// Bench for sti_dac_sequencer: frame-level reference model feeding a scoreboard.
module tb_sti_dac_sequencer;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load = 1'b0;
  logic [15:0]       pi_data = 16'h0;
  logic [1:0]        pi_length = 2'b00;
  logic              pi_fill = 1'b0;
  logic              pi_msb = 1'b0;
  logic              pi_low = 1'b0;
  logic              pi_end = 1'b0;
  logic              busy;
  logic              so_valid;
  logic              so_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              done;

  sti_dac_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .busy(busy), .so_valid(so_valid), .so_data(so_data), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [0:0]          so_q[$];
  logic [ADDR_W+7:0]   exp_q[$];
  int                  exp_done = 0;
  logic [ADDR_W-1:0]   m_addr = '0;
  logic [7:0]          last_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  task automatic clear_model();
    so_q.delete();
    exp_q.delete();
    exp_done  = 0;
    m_addr    = '0;
    last_data = 8'h00;
  endtask

  // Reference model: builds the stream as a list of bits, cuts it into bytes,
  // and appends zero bytes up to the top of memory for a last frame.
  task automatic model_frame(input logic [15:0] d, input logic [1:0] len,
                             input logic fill, input logic msb, input logic low,
                             input logic endf, output int exp_busy);
    int          n;
    logic [31:0] w;
    logic        bits[$];
    logic [7:0]  byte_v;
    n = 8 * (int'(len) + 1);
    case (len)
      2'd0: w = low ? {24'h0, d[7:0]} : {24'h0, d[15:8]};
      2'd1: w = {16'h0, d};
      2'd2: w = fill ? {8'h0, d, 8'h0} : {16'h0, d};
      default: w = fill ? {d, 16'h0} : {16'h0, d};
    endcase
    for (int i = 0; i < n; i++) bits.push_back(msb ? w[n-1-i] : w[i]);
    for (int i = 0; i < n; i++) so_q.push_back(bits[i]);
    for (int j = 0; j < n / 8; j++) begin
      for (int b = 0; b < 8; b++) byte_v[7-b] = bits[8*j+b];
      exp_q.push_back({m_addr, byte_v});
      m_addr = m_addr + 1'b1;
    end
    exp_busy = n + 1;
    if (endf) begin
      while (m_addr != '0) begin
        exp_q.push_back({m_addr, 8'h00});
        m_addr = m_addr + 1'b1;
        exp_busy++;
      end
      exp_busy++;
      exp_done++;
    end
  endtask

  // Driver: one frame; optional extra load pulse and optional reset at cycle T+i.
  task automatic send(input logic [15:0] d, input logic [1:0] len, input logic fill,
                      input logic msb, input logic low, input logic endf,
                      input int extra_at, input int rst_at);
    int i;
    int exp_busy;
    i = 0;
    while (busy && i < 1000) begin
      @(negedge clk);
      i++;
    end
    if (busy) fail("idle_timeout");
    pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low; pi_end = endf;
    load = 1'b1;
    model_frame(d, len, fill, msb, low, endf, exp_busy);
    i = 0;
    do begin
      @(negedge clk);
      i++;
      if (i == 1) begin
        load      = 1'b0;
        pi_data   = 16'($urandom);
        pi_length = 2'($urandom_range(0, 3));
        pi_fill   = 1'($urandom);
        pi_msb    = 1'($urandom);
        pi_low    = 1'($urandom);
        pi_end    = 1'($urandom);
      end
      if (i == extra_at) begin
        load    = 1'b1;
        pi_data = ~d;
        pi_end  = 1'b1;
      end
      if (extra_at > 0 && i == extra_at + 1) load = 1'b0;
      if (rst_at > 0 && i == rst_at) rst = 1'b1;
      if (rst_at > 0 && i == rst_at + 1) begin
        rst = 1'b0;
        chk("midreset_outputs", {busy, so_valid, so_data, mem_we, mem_addr, mem_data, done}, 0);
        clear_model();
        return;
      end
    end while (busy && i < 2000);
    chk("busy_cycles", i - 1, exp_busy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
    chk("reset_outputs", {busy, so_valid, so_data, mem_we, mem_addr, mem_data, done}, 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (so_valid) begin
        if (so_q.size() == 0) fail("so_unexpected");
        else chk("so_data", so_data, so_q.pop_front());
      end else begin
        chk("so_idle_zero", so_data, 0);
      end
      if (mem_we) begin
        if (exp_q.size() == 0) fail("write_unexpected");
        else chk("mem_write", {mem_addr, mem_data}, exp_q.pop_front());
        last_data = mem_data;
      end else begin
        chk("mem_data_hold", mem_data, last_data);
      end
      if (done) begin
        chk("done_expected", exp_done > 0, 1);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // 8-bit MSB-first high byte, then LSB-first low byte
    send(16'hA5C1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    send(16'hA5C1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    // 32-bit fill variants
    do_reset();
    send(16'h1234, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    send(16'h1234, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    send(16'h1234, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    // load during a busy frame is ignored
    send(16'hBEEF, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
    // last frame with zero fill, then addressing restarts at 0
    do_reset();
    send(16'h5A5A, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    send(16'hC3C3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    send(16'h0F0F, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    // memory exactly full on the last frame: no fill writes
    do_reset();
    for (int f = 0; f < DEPTH / 2; f++)
      send(16'($urandom), 2'd1, 1'b0, 1'($urandom), 1'b0, (f == DEPTH / 2 - 1), 0, 0);
    // reset at the 5th bit of a 16-bit frame, then a fresh frame at addr 0
    send(16'hFFFF, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 5);
    send(16'h8001, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    // random frames
    for (int r = 0; r < 30; r++)
      send(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 5) == 0), 0, 0);
    repeat (3) @(negedge clk);
    chk("so_queue_empty", so_q.size(), 0);
    chk("write_queue_empty", exp_q.size(), 0);
    chk("done_all_seen", exp_done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
